// File: rtl/uart_buf_pkg.sv
// Shared constants and types for the UART buffering bridge.
package uart_buf_pkg;

    localparam int unsigned DEPTH_LOG2_DEF = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;

    // The UART reports "no byte present" with an all-ones data word
    localparam logic [WORD_W-1:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/uart_buf_fifo.sv
// Synchronous byte FIFO with registered level/non-empty flags and a
// first-word-fall-through head.
module uart_buf_fifo
    import uart_buf_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_push,
    input  logic [BYTE_W-1:0]     i_data,
    input  logic                  i_pop,
    output logic [BYTE_W-1:0]     o_head,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_nonempty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_nonempty;

    logic              w_push;
    logic              w_pop;
    logic [LVL_W-1:0]  w_level_nxt;

    // Pop needs data; push needs room unless a pop frees a slot this cycle
    always_comb begin
        w_pop       = i_pop && r_nonempty;
        w_push      = i_push && (!r_level[LVL_W-1] || w_pop);
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_nonempty <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level    <= w_level_nxt;
            r_nonempty <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_full     = r_level[LVL_W-1];
    assign o_nonempty = r_nonempty;

endmodule

// File: rtl/uart_buf_bridge.sv
// CPU-side byte buffering between a CPU and a word-wide UART data register.
// Define UART_BUF_RX_EN to build the RX FIFO/FSM; otherwise RX is a pass-through.
module uart_buf_bridge
    import uart_buf_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_tx_we,
    input  logic [BYTE_W-1:0]     cpu_tx_data,
    output logic                  cpu_tx_full,
    output logic [DEPTH_LOG2:0]   cpu_tx_level,
    input  logic                  cpu_rx_re,
    output logic [WORD_W-1:0]     cpu_rx_data,
    output logic [DEPTH_LOG2:0]   cpu_rx_level,
    output logic                  rx_overflow,
    input  logic                  ovf_clr,
    output logic                  uart_dat_we,
    output logic [WORD_W-1:0]     uart_dat_di,
    input  logic                  uart_dat_wait,
    output logic                  uart_dat_re,
    input  logic [WORD_W-1:0]     uart_dat_do
);

    localparam int unsigned PAD_W = WORD_W - BYTE_W;

    logic              w_tx_pop;
    logic [BYTE_W-1:0] w_tx_head;

    // The write strobe is the registered non-empty flag, so the head is
    // offered every cycle and only leaves when the UART is not busy
    assign w_tx_pop    = uart_dat_we && !uart_dat_wait;
    assign uart_dat_di = {PAD_W'(0), w_tx_head};

    uart_buf_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (cpu_tx_we),
        .i_data     (cpu_tx_data),
        .i_pop      (w_tx_pop),
        .o_head     (w_tx_head),
        .o_level    (cpu_tx_level),
        .o_full     (cpu_tx_full),
        .o_nonempty (uart_dat_we)
    );

`ifdef UART_BUF_RX_EN

    rx_state_e         r_rx_state;
    rx_state_e         w_rx_state_nxt;
    logic              r_dat_re;
    logic              w_dat_re_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              w_capture;
    logic              w_rx_full;
    logic              w_rx_nonempty;
    logic [BYTE_W-1:0] w_rx_head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_state <= RX_IDLE;
            r_dat_re   <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_dat_re   <= w_dat_re_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    // Capture a byte, then spend one cycle strobing the read while the UART drops valid
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_dat_re_nxt   = 1'b0;
        w_capture      = 1'b0;
        w_ovf_nxt      = r_ovf;
        case (r_rx_state)
            RX_IDLE: begin
                if (uart_dat_do != RX_EMPTY_WORD) begin
                    w_capture      = 1'b1;
                    w_dat_re_nxt   = 1'b1;
                    w_rx_state_nxt = RX_ACK;
                end
            end
            RX_ACK: begin
                w_rx_state_nxt = RX_IDLE;
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
        if (ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end
        if (w_capture && w_rx_full && !cpu_rx_re) begin
            w_ovf_nxt = 1'b1;
        end
    end

    uart_buf_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_capture),
        .i_data     (uart_dat_do[BYTE_W-1:0]),
        .i_pop      (cpu_rx_re),
        .o_head     (w_rx_head),
        .o_level    (cpu_rx_level),
        .o_full     (w_rx_full),
        .o_nonempty (w_rx_nonempty)
    );

    assign cpu_rx_data = w_rx_nonempty ? {PAD_W'(0), w_rx_head} : RX_EMPTY_WORD;
    assign uart_dat_re = r_dat_re;
    assign rx_overflow = r_ovf;

`else

    logic w_unused_ovf_clr;

    assign cpu_rx_data      = uart_dat_do;
    assign uart_dat_re      = cpu_rx_re;
    assign cpu_rx_level     = '0;
    assign rx_overflow      = 1'b0;
    assign w_unused_ovf_clr = ovf_clr;

`endif

endmodule

// File: tb/tb_uart_buf_bridge.sv
// Directed bench for uart_buf_bridge: queue-based model checked every cycle,
// plus hand-computed expectations for the listed scenarios.
module tb_uart_buf_bridge;

    localparam int DEPTH = 16;

    logic        clk;
    logic        resetn;
    logic        cpu_tx_we;
    logic [7:0]  cpu_tx_data;
    logic        cpu_tx_full;
    logic [4:0]  cpu_tx_level;
    logic        cpu_rx_re;
    logic [31:0] cpu_rx_data;
    logic [4:0]  cpu_rx_level;
    logic        rx_overflow;
    logic        ovf_clr;
    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_wait;
    logic        uart_dat_re;
    logic [31:0] uart_dat_do;

    int checks = 0;
    int errors = 0;

    uart_buf_bridge #(.DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_tx_we     (cpu_tx_we),
        .cpu_tx_data   (cpu_tx_data),
        .cpu_tx_full   (cpu_tx_full),
        .cpu_tx_level  (cpu_tx_level),
        .cpu_rx_re     (cpu_rx_re),
        .cpu_rx_data   (cpu_rx_data),
        .cpu_rx_level  (cpu_rx_level),
        .rx_overflow   (rx_overflow),
        .ovf_clr       (ovf_clr),
        .uart_dat_we   (uart_dat_we),
        .uart_dat_di   (uart_dat_di),
        .uart_dat_wait (uart_dat_wait),
        .uart_dat_re   (uart_dat_re),
        .uart_dat_do   (uart_dat_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: TX/RX contents as byte queues, updated from the inputs at each edge
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit         m_busy;
    bit         m_re;
    bit         m_ovf;
    bit         m_tpop;
    bit         m_rpop;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tx.delete();
            m_rx.delete();
            m_busy = 1'b0;
            m_re   = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_tpop = (m_tx.size() != 0) && !uart_dat_wait;
            if (m_tpop) void'(m_tx.pop_front());
            if (cpu_tx_we && m_tx.size() < DEPTH) m_tx.push_back(cpu_tx_data);
`ifdef UART_BUF_RX_EN
            m_rpop = cpu_rx_re && (m_rx.size() != 0);
            if (m_rpop) void'(m_rx.pop_front());
            if (ovf_clr) m_ovf = 1'b0;
            // After taking a byte the bridge ignores the UART for one cycle
            if (!m_busy && uart_dat_do != 32'hFFFF_FFFF) begin
                m_busy = 1'b1;
                m_re   = 1'b1;
                if (m_rx.size() < DEPTH) m_rx.push_back(uart_dat_do[7:0]);
                else m_ovf = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_re   = 1'b0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        chk("tx_we", 32'(uart_dat_we), 32'(m_tx.size() != 0));
        chk("tx_level", 32'(cpu_tx_level), 32'(m_tx.size()));
        chk("tx_full", 32'(cpu_tx_full), 32'(m_tx.size() == DEPTH));
        if (m_tx.size() != 0) chk("tx_di", uart_dat_di, {24'h0, m_tx[0]});
`ifdef UART_BUF_RX_EN
        chk("rx_level", 32'(cpu_rx_level), 32'(m_rx.size()));
        chk("rx_data", cpu_rx_data, (m_rx.size() != 0) ? {24'h0, m_rx[0]} : 32'hFFFF_FFFF);
        chk("rx_re", 32'(uart_dat_re), 32'(m_re));
        chk("rx_ovf", 32'(rx_overflow), 32'(m_ovf));
`else
        chk("rx_data_pt", cpu_rx_data, uart_dat_do);
        chk("rx_re_pt", 32'(uart_dat_re), 32'(cpu_rx_re));
        chk("rx_level_pt", 32'(cpu_rx_level), 32'd0);
        chk("rx_ovf_pt", 32'(rx_overflow), 32'd0);
`endif
    end

`ifdef UART_BUF_RX_EN
    // Acts as the UART: hold the byte valid until the bridge strobes a read
    task automatic uart_send(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        uart_dat_do = {24'h0, b};
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (uart_dat_re) seen = 1'b1;
        end
        chk("uart_re_seen", 32'(seen), 32'd1);
        step();
        uart_dat_do = 32'hFFFF_FFFF;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        cpu_tx_we     = 1'b0;
        cpu_tx_data   = 8'h00;
        cpu_rx_re     = 1'b0;
        ovf_clr       = 1'b0;
        uart_dat_wait = 1'b0;
        uart_dat_do   = 32'hFFFF_FFFF;
        #12;
        chk("rst_tx_level", 32'(cpu_tx_level), 32'd0);
        chk("rst_tx_we", 32'(uart_dat_we), 32'd0);
        chk("rst_rx_data", cpu_rx_data, 32'hFFFF_FFFF);
        chk("rst_rx_re", 32'(uart_dat_re), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Two bytes, UART always ready
        cpu_tx_we = 1'b1; cpu_tx_data = 8'h41;
        step();
        cpu_tx_data = 8'h42;
        chk("t1_we", 32'(uart_dat_we), 32'd1);
        chk("t1_di41", uart_dat_di, 32'h0000_0041);
        step();
        cpu_tx_we = 1'b0;
        chk("t1_di42", uart_dat_di, 32'h0000_0042);
        step();
        chk("t1_level0", 32'(cpu_tx_level), 32'd0);
        chk("t1_we0", 32'(uart_dat_we), 32'd0);

        // Head held while the UART is busy
        uart_dat_wait = 1'b1;
        cpu_tx_we = 1'b1; cpu_tx_data = 8'h55;
        step();
        cpu_tx_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t2_di55", uart_dat_di, 32'h0000_0055);
            chk("t2_level1", 32'(cpu_tx_level), 32'd1);
            step();
        end
        uart_dat_wait = 1'b0;
        step();
        chk("t2_drained", 32'(cpu_tx_level), 32'd0);

        // Overfill: 17 pushes while busy
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cpu_tx_we = 1'b1; cpu_tx_data = 8'(8'h10 + i);
            step();
        end
        cpu_tx_we = 1'b0;
        chk("t3_full", 32'(cpu_tx_full), 32'd1);
        chk("t3_level16", 32'(cpu_tx_level), 32'd16);
        chk("t3_head", uart_dat_di, 32'h0000_0010);
        // Push and pop together while full
        uart_dat_wait = 1'b0;
        cpu_tx_we = 1'b1; cpu_tx_data = 8'h99;
        step();
        cpu_tx_we = 1'b0;
        chk("t3_pushpop_level", 32'(cpu_tx_level), 32'd16);
        chk("t3_pushpop_head", uart_dat_di, 32'h0000_0011);
        for (int i = 0; i < 16; i++) step();
        chk("t3_drained", 32'(cpu_tx_level), 32'd0);

`ifdef UART_BUF_RX_EN
        // Single byte whose value is 0xFF
        uart_send(8'hFF);
        chk("r1_level", 32'(cpu_rx_level), 32'd1);
        chk("r1_data", cpu_rx_data, 32'h0000_00FF);
        cpu_rx_re = 1'b1;
        step();
        chk("r1_popped", cpu_rx_data, 32'hFFFF_FFFF);
        step();
        cpu_rx_re = 1'b0;
        chk("r1_empty_pop", 32'(cpu_rx_level), 32'd0);

        // Fill, then overflow
        for (int i = 0; i < 16; i++) uart_send(8'(8'h20 + i));
        chk("r2_level16", 32'(cpu_rx_level), 32'd16);
        chk("r2_noovf", 32'(rx_overflow), 32'd0);
        uart_send(8'hEE);
        chk("r2_level_kept", 32'(cpu_rx_level), 32'd16);
        chk("r2_ovf", 32'(rx_overflow), 32'd1);
        chk("r2_head", cpu_rx_data, 32'h0000_0020);
        for (int i = 0; i < 5; i++) step();
        chk("r2_ovf_sticky", 32'(rx_overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("r2_ovf_clr", 32'(rx_overflow), 32'd0);

        // Overflow set wins over clear in the same cycle
        uart_dat_do = 32'h0000_00A5; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("r3_re", 32'(uart_dat_re), 32'd1);
        chk("r3_ovf_prio", 32'(rx_overflow), 32'd1);
        step();
        uart_dat_do = 32'hFFFF_FFFF;
        step();

        // Capture and pop together while full
        uart_dat_do = 32'h0000_005A; cpu_rx_re = 1'b1;
        step();
        cpu_rx_re = 1'b0;
        chk("r4_level16", 32'(cpu_rx_level), 32'd16);
        chk("r4_head", cpu_rx_data, 32'h0000_0021);
        chk("r4_ovf_kept", 32'(rx_overflow), 32'd1);
        step();
        uart_dat_do = 32'hFFFF_FFFF;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        cpu_rx_re = 1'b1;
        for (int i = 0; i < 16; i++) step();
        cpu_rx_re = 1'b0;
        chk("r4_drained", 32'(cpu_rx_level), 32'd0);

        uart_send(8'h01);
        uart_send(8'h02);
`else
        uart_dat_do = 32'h1234_5678; cpu_rx_re = 1'b1;
        #1;
        chk("pt_data", cpu_rx_data, 32'h1234_5678);
        chk("pt_re", 32'(uart_dat_re), 32'd1);
        step();
        cpu_rx_re = 1'b0; ovf_clr = 1'b1;
        #1;
        chk("pt_re0", 32'(uart_dat_re), 32'd0);
        chk("pt_ovf", 32'(rx_overflow), 32'd0);
        step();
        ovf_clr = 1'b0; uart_dat_do = 32'hFFFF_FFFF;
        step();
`endif

        // Reset mid-transfer with five bytes queued
        uart_dat_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_tx_we = 1'b1; cpu_tx_data = 8'(8'h60 + i);
            step();
        end
        cpu_tx_we = 1'b0;
        chk("t5_level5", 32'(cpu_tx_level), 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_rst_tx_level", 32'(cpu_tx_level), 32'd0);
        chk("t5_rst_we", 32'(uart_dat_we), 32'd0);
        chk("t5_rst_rx_level", 32'(cpu_rx_level), 32'd0);
        chk("t5_rst_rx_data", cpu_rx_data, 32'hFFFF_FFFF);
        step();
        resetn = 1'b1;
        uart_dat_wait = 1'b0;
        step();
        step();
        chk("t5_after_level", 32'(cpu_tx_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
